// File: rtl/lms_spi_pkg.sv
// Shared definitions for the LMS SPI master/slave pair: register map,
// status/control bit positions and the frame state encoding.
package lms_spi_pkg;

    // Register port addresses
    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

    // Status bit positions; control uses the same positions as interrupt enables
    localparam int unsigned STAT_TUR  = 1;
    localparam int unsigned STAT_ABT  = 2;
    localparam int unsigned STAT_ROE  = 3;
    localparam int unsigned STAT_TOE  = 4;
    localparam int unsigned STAT_TMT  = 5;
    localparam int unsigned STAT_TRDY = 6;
    localparam int unsigned STAT_RRDY = 7;
    localparam int unsigned STAT_E    = 8;
    localparam int unsigned STAT_EOP  = 9;

    // Frame state
    typedef enum logic {
        FRAME_IDLE   = 1'b0,
        FRAME_ACTIVE = 1'b1
    } frame_state_e;

endpackage

// File: rtl/lms_spi_sync_edge.sv
// N-stage synchronizer for an asynchronous input, with one history flop
// for single-cycle rise/fall pulses in the clk domain.
module lms_spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    output logic s_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift chain and history next-state
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d_in;
        hist_d    = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer flops reset to the line's idle level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign s_out = sync_q[SYNC_STAGES-1];
    assign rise  = s_out & ~hist_q;
    assign fall  = ~s_out & hist_q;

endmodule

// File: rtl/lms_spi_slave_8b.sv
// SPI slave (CPOL=0, CPHA=1, MSB first) with an Avalon-style two-cycle
// register port. SCLK/MOSI/SS_n are oversampled in the clk domain.
module lms_spi_slave_8b
    import lms_spi_pkg::*;
#(
    parameter int unsigned          DATABITS    = 8,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [DATABITS-1:0]  IDLE_MISO   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISO_oe
);

    // Synchronized SPI lines
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic ss_s, ss_rise, ss_fall;
    logic sync_unused;

    lms_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d_in(SCLK),
        .s_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    lms_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d_in(MOSI),
        .s_out(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    lms_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d_in(SS_n),
        .s_out(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    assign sync_unused = ^{sclk_s, mosi_rise, mosi_fall};

    // State
    frame_state_e          state_q, state_d;
    logic [3:0]            bitcnt_q, bitcnt_d;
    logic [DATABITS-1:0]   tx_shift_q, tx_shift_d;
    logic [DATABITS-1:0]   rx_shift_q, rx_shift_d;
    logic [DATABITS-1:0]   tx_hold_q, tx_hold_d;
    logic [DATABITS-1:0]   rx_hold_q, rx_hold_d;
    logic                  tx_primed_q, tx_primed_d;
    logic                  underrun_pend_q, underrun_pend_d;
    logic                  miso_q, miso_d;
    logic                  eop_q, eop_d;
    logic                  roe_q, roe_d;
    logic                  toe_q, toe_d;
    logic                  tur_q, tur_d;
    logic                  abt_q, abt_d;
    logic                  rrdy_q, rrdy_d;
    logic [9:1]            ctrl_q, ctrl_d;
    logic [15:0]           eopval_q, eopval_d;
    logic                  rd_strobe_q, rd_strobe_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [2:0]            addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           data_to_cpu_q, data_to_cpu_d;
    logic                  irq_q, irq_d;

    logic [15:0]           status_w;
    logic [15:0]           rd_mux;
    logic                  trdy_w, tmt_w;
    logic                  rx_read, st_write, tx_write;
    logic                  reload;
    logic [DATABITS-1:0]   rx_new;

    assign trdy_w = ~tx_primed_q;
    assign tmt_w  = ~tx_primed_q & (state_q == FRAME_IDLE);

    // Status word and read-data mux for the register port
    always_comb begin
        status_w            = '0;
        status_w[STAT_EOP]  = eop_q;
        status_w[STAT_E]    = roe_q | toe_q | tur_q | abt_q;
        status_w[STAT_RRDY] = rrdy_q;
        status_w[STAT_TRDY] = trdy_w;
        status_w[STAT_TMT]  = tmt_w;
        status_w[STAT_TOE]  = toe_q;
        status_w[STAT_ROE]  = roe_q;
        status_w[STAT_ABT]  = abt_q;
        status_w[STAT_TUR]  = tur_q;

        case (mem_addr)
            ADDR_RXDATA:  rd_mux = 16'(rx_hold_q);
            ADDR_STATUS:  rd_mux = status_w;
            ADDR_CONTROL: rd_mux = {6'b0, ctrl_q, 1'b0};
            ADDR_EOPVAL:  rd_mux = eopval_q;
            default:      rd_mux = '0;
        endcase
    end

    // Next-state: bus strobes, register side effects and the frame FSM.
    // Clears are applied before sets so that set events win on collision;
    // the tx reload is applied before a txdata write so the write lands in
    // the holding register it just vacated.
    always_comb begin
        state_d         = state_q;
        bitcnt_d        = bitcnt_q;
        tx_shift_d      = tx_shift_q;
        rx_shift_d      = rx_shift_q;
        tx_hold_d       = tx_hold_q;
        rx_hold_d       = rx_hold_q;
        tx_primed_d     = tx_primed_q;
        underrun_pend_d = underrun_pend_q;
        miso_d          = miso_q;
        eop_d           = eop_q;
        roe_d           = roe_q;
        toe_d           = toe_q;
        tur_d           = tur_q;
        abt_d           = abt_q;
        rrdy_d          = rrdy_q;
        ctrl_d          = ctrl_q;
        eopval_d        = eopval_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        data_to_cpu_d   = data_to_cpu_q;
        reload          = 1'b0;
        rx_new          = {rx_shift_q[DATABITS-2:0], mosi_s};

        // Request -> strobe on the following cycle, one strobe per access
        rd_strobe_d = spi_select & ~read_n & ~rd_strobe_q;
        wr_strobe_d = spi_select & ~write_n & ~wr_strobe_q;
        if (rd_strobe_d | wr_strobe_d) begin
            addr_d  = mem_addr;
            wdata_d = data_from_cpu;
        end
        if (rd_strobe_d) begin
            data_to_cpu_d = rd_mux;
        end

        rx_read  = rd_strobe_q & (addr_q == ADDR_RXDATA);
        st_write = wr_strobe_q & (addr_q == ADDR_STATUS);
        tx_write = wr_strobe_q & (addr_q == ADDR_TXDATA);

        if (rx_read) begin
            rrdy_d = 1'b0;
        end
        if (st_write) begin
            eop_d  = 1'b0;
            roe_d  = 1'b0;
            toe_d  = 1'b0;
            tur_d  = 1'b0;
            abt_d  = 1'b0;
            rrdy_d = 1'b0;
        end
        if (wr_strobe_q && addr_q == ADDR_CONTROL) begin
            ctrl_d = wdata_q[9:1];
        end
        if (wr_strobe_q && addr_q == ADDR_EOPVAL) begin
            eopval_d = wdata_q;
        end

        case (state_q)
            FRAME_IDLE: begin
                if (ss_fall) begin
                    state_d  = FRAME_ACTIVE;
                    bitcnt_d = '0;
                    reload   = 1'b1;
                end
            end
            FRAME_ACTIVE: begin
                if (ss_rise) begin
                    state_d  = FRAME_IDLE;
                    if (bitcnt_q != '0) begin
                        abt_d = 1'b1;
                    end
                    bitcnt_d = '0;
                    miso_d   = 1'b0;
                end else if (sclk_rise) begin
                    miso_d     = tx_shift_q[DATABITS-1];
                    tx_shift_d = tx_shift_q << 1;
                    if (underrun_pend_q && bitcnt_q == '0) begin
                        tur_d           = 1'b1;
                        underrun_pend_d = 1'b0;
                    end
                end else if (sclk_fall) begin
                    rx_shift_d = rx_new;
                    if (bitcnt_q == 4'(DATABITS - 1)) begin
                        rx_hold_d = rx_new;
                        if (rrdy_q && !rx_read) begin
                            roe_d = 1'b1;
                        end
                        rrdy_d = 1'b1;
                        if (rx_new == eopval_q[DATABITS-1:0]) begin
                            eop_d = 1'b1;
                        end
                        bitcnt_d = '0;
                        reload   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            default: state_d = FRAME_IDLE;
        endcase

        if (reload) begin
            if (tx_primed_q) begin
                tx_shift_d      = tx_hold_q;
                tx_primed_d     = 1'b0;
                underrun_pend_d = 1'b0;
            end else begin
                tx_shift_d      = IDLE_MISO;
                underrun_pend_d = 1'b1;
            end
        end

        if (tx_write) begin
            if (!tx_primed_d) begin
                tx_hold_d   = wdata_q[DATABITS-1:0];
                tx_primed_d = 1'b1;
            end else begin
                toe_d = 1'b1;
            end
        end

        irq_d = |(status_w[9:1] & ctrl_q);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= FRAME_IDLE;
            bitcnt_q        <= '0;
            tx_shift_q      <= '0;
            rx_shift_q      <= '0;
            tx_hold_q       <= '0;
            rx_hold_q       <= '0;
            tx_primed_q     <= 1'b0;
            underrun_pend_q <= 1'b0;
            miso_q          <= 1'b0;
            eop_q           <= 1'b0;
            roe_q           <= 1'b0;
            toe_q           <= 1'b0;
            tur_q           <= 1'b0;
            abt_q           <= 1'b0;
            rrdy_q          <= 1'b0;
            ctrl_q          <= '0;
            eopval_q        <= '0;
            rd_strobe_q     <= 1'b0;
            wr_strobe_q     <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            data_to_cpu_q   <= '0;
            irq_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            bitcnt_q        <= bitcnt_d;
            tx_shift_q      <= tx_shift_d;
            rx_shift_q      <= rx_shift_d;
            tx_hold_q       <= tx_hold_d;
            rx_hold_q       <= rx_hold_d;
            tx_primed_q     <= tx_primed_d;
            underrun_pend_q <= underrun_pend_d;
            miso_q          <= miso_d;
            eop_q           <= eop_d;
            roe_q           <= roe_d;
            toe_q           <= toe_d;
            tur_q           <= tur_d;
            abt_q           <= abt_d;
            rrdy_q          <= rrdy_d;
            ctrl_q          <= ctrl_d;
            eopval_q        <= eopval_d;
            rd_strobe_q     <= rd_strobe_d;
            wr_strobe_q     <= wr_strobe_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            data_to_cpu_q   <= data_to_cpu_d;
            irq_q           <= irq_d;
        end
    end

    assign data_to_cpu   = data_to_cpu_q;
    assign irq           = irq_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = trdy_w;
    assign endofpacket   = eop_q;
    assign MISO_oe       = ~ss_s;
    assign MISO          = miso_q & MISO_oe;

endmodule

// File: tb/tb_lms_spi_slave_8b.sv
// Directed bench for lms_spi_slave_8b: register-map table plus hand-written
// SPI frame sequences driven as a CPOL=0/CPHA=1 master at clk/8.
module tb_lms_spi_slave_8b;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        read_n, write_n, spi_select;
    logic        irq, dataavailable, readyfordata, endofpacket;
    logic        SCLK, MOSI, SS_n, MISO, MISO_oe;

    int n_vec = 0;
    int n_err = 0;

    lms_spi_slave_8b #(.DATABITS(8), .SYNC_STAGES(2), .IDLE_MISO(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
        .irq(irq), .dataavailable(dataavailable), .readyfordata(readyfordata),
        .endofpacket(endofpacket), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
        .MISO(MISO), .MISO_oe(MISO_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } reg_vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        @(negedge clk);
        @(negedge clk);
        d = data_to_cpu;
        spi_select = 1'b0; read_n = 1'b1;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        logic [7:0] t;
        t  = tx;
        rx = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            SCLK = 1'b1; MOSI = t[7]; t = t << 1;
            repeat (4) @(negedge clk);
            rx = {rx[6:0], MISO};
            SCLK = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic ss_low();
        @(negedge clk); SS_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        @(negedge clk); SS_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    reg_vec_t   tbl[$];
    logic [15:0] rd;
    logic [7:0]  r1, r2;

    initial begin
        reset_n = 1'b0; mem_addr = '0; data_from_cpu = '0;
        read_n = 1'b1; write_n = 1'b1; spi_select = 1'b0;
        SCLK = 1'b0; MOSI = 1'b0; SS_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst data_to_cpu", data_to_cpu, 16'h0000);
        check("rst irq", 16'(irq), 16'h0);
        check("rst MISO", 16'(MISO), 16'h0);
        check("rst MISO_oe", 16'(MISO_oe), 16'h0);
        check("rst readyfordata", 16'(readyfordata), 16'h1);
        check("rst dataavailable", 16'(dataavailable), 16'h0);
        check("rst endofpacket", 16'(endofpacket), 16'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Register map table
        tbl.push_back('{1'b0, 3'd2, 16'h0000, 16'h0060});
        tbl.push_back('{1'b0, 3'd3, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 3'd6, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 3'd3, 16'hFFFF, 16'h0000});
        tbl.push_back('{1'b0, 3'd3, 16'h0000, 16'h03FE});
        tbl.push_back('{1'b1, 3'd3, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 3'd3, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 3'd6, 16'h1234, 16'h0000});
        tbl.push_back('{1'b0, 3'd6, 16'h0000, 16'h1234});
        tbl.push_back('{1'b1, 3'd4, 16'hFFFF, 16'h0000});
        tbl.push_back('{1'b0, 3'd4, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 3'd5, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 3'd7, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 3'd0, 16'h0000, 16'h0000});
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                reg_write(tbl[i].addr, tbl[i].data);
            end else begin
                reg_read(tbl[i].addr, rd);
                check($sformatf("table[%0d] addr %0d", i, tbl[i].addr), rd, tbl[i].exp);
            end
        end

        // irq follows enabled status bits, registered
        reg_write(3'd3, 16'h0040);
        repeat (2) @(negedge clk);
        check("irq TRDY enabled", 16'(irq), 16'h1);
        reg_write(3'd3, 16'h0000);
        repeat (2) @(negedge clk);
        check("irq disabled", 16'(irq), 16'h0);

        // 1: preloaded txdata A5, master sends 3C
        reg_write(3'd1, 16'h00A5);
        check("t1 readyfordata", 16'(readyfordata), 16'h0);
        reg_read(3'd2, rd);
        check("t1 status primed", rd, 16'h0000);
        reg_write(3'd3, 16'h0080);
        ss_low();
        check("t1 MISO_oe", 16'(MISO_oe), 16'h1);
        spi_bits(8'h3C, 8, r1);
        check("t1 MISO byte", 16'(r1), 16'h00A5);
        ss_high();
        check("t1 dataavailable", 16'(dataavailable), 16'h1);
        check("t1 irq", 16'(irq), 16'h1);
        check("t1 MISO_oe idle", 16'(MISO_oe), 16'h0);
        reg_read(3'd0, rd);
        check("t1 rxdata", rd, 16'h003C);
        reg_read(3'd2, rd);
        check("t1 status after read", rd, 16'h0060);
        repeat (2) @(negedge clk);
        check("t1 irq cleared", 16'(irq), 16'h0);

        // 2: two bytes in one frame, no intermediate read
        ss_low();
        spi_bits(8'h11, 8, r1);
        spi_bits(8'h22, 8, r2);
        ss_high();
        check("t2 MISO underrun byte0", 16'(r1), 16'h00FF);
        check("t2 MISO underrun byte1", 16'(r2), 16'h00FF);
        reg_read(3'd2, rd);
        check("t2 status ROE/E", rd, 16'h01EA);
        reg_read(3'd0, rd);
        check("t2 rxdata", rd, 16'h0022);
        reg_write(3'd2, 16'h0000);
        reg_read(3'd2, rd);
        check("t2 status cleared", rd, 16'h0060);

        // 3: no preload, TUR right after the first SCLK rise
        ss_low();
        spi_bits(8'h5A, 1, r1);
        reg_read(3'd2, rd);
        check("t3 status TUR mid-frame", rd, 16'h0142);
        spi_bits(8'hB4, 7, r2);
        ss_high();
        check("t3 MISO byte", 16'({r1[0], r2[6:0]}), 16'h00FF);
        reg_read(3'd2, rd);
        check("t3 status", rd, 16'h01E2);

        // 4: abort after 5 falls, RRDY and holding untouched
        ss_low();
        spi_bits(8'hC3, 5, r1);
        ss_high();
        reg_read(3'd2, rd);
        check("t4 status ABT", rd, 16'h01E6);
        check("t4 dataavailable", 16'(dataavailable), 16'h1);
        reg_read(3'd0, rd);
        check("t4 rxdata kept", rd, 16'h005A);
        reg_write(3'd2, 16'h0000);
        reg_write(3'd1, 16'h0096);
        ss_low();
        spi_bits(8'hC3, 8, r1);
        ss_high();
        check("t4 next MISO", 16'(r1), 16'h0096);
        reg_read(3'd0, rd);
        check("t4 next rxdata", rd, 16'h00C3);
        reg_read(3'd2, rd);
        check("t4 status clean", rd, 16'h0060);

        // 5: double txdata write
        reg_write(3'd1, 16'h0011);
        reg_write(3'd1, 16'h0022);
        reg_read(3'd2, rd);
        check("t5 status TOE", rd, 16'h0110);
        reg_write(3'd2, 16'h0000);
        reg_read(3'd2, rd);
        check("t5 status after clear", rd, 16'h0000);
        check("t5 readyfordata", 16'(readyfordata), 16'h0);
        ss_low();
        spi_bits(8'h00, 8, r1);
        ss_high();
        check("t5 holding kept first", 16'(r1), 16'h0011);
        reg_read(3'd0, rd);
        check("t5 rxdata", rd, 16'h0000);

        // 6: EOP match, then asynchronous reset mid-frame
        reg_write(3'd6, 16'h007E);
        ss_low();
        spi_bits(8'h7E, 8, r1);
        ss_high();
        check("t6 endofpacket", 16'(endofpacket), 16'h1);
        check("t6 irq", 16'(irq), 16'h1);
        reg_read(3'd2, rd);
        check("t6 status EOP", rd, 16'h03E2);
        ss_low();
        spi_bits(8'h55, 3, r1);
        @(negedge clk);
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
        check("t6 MISO before reset", 16'(MISO), 16'h1);
        #2 reset_n = 1'b0;
        #1;
        check("t6 async data_to_cpu", data_to_cpu, 16'h0000);
        check("t6 async irq", 16'(irq), 16'h0);
        check("t6 async MISO", 16'(MISO), 16'h0);
        check("t6 async MISO_oe", 16'(MISO_oe), 16'h0);
        check("t6 async readyfordata", 16'(readyfordata), 16'h1);
        check("t6 async dataavailable", 16'(dataavailable), 16'h0);
        check("t6 async endofpacket", 16'(endofpacket), 16'h0);
        SCLK = 1'b0; SS_n = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        reg_read(3'd2, rd);
        check("t6 status after reset", rd, 16'h0060);
        reg_read(3'd6, rd);
        check("t6 eopval after reset", rd, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
